controle_execucao: RTL and testbench
====================================

# controle_execucao

Execution controller for the single-cycle processor datapath. It decodes the current instruction's OpCode and gates PC advance (HLT) and register write-back. Execution freezes on an IN instruction until a debounced button press, freezes permanently on HLT, and supports single-step mode. It also counts retired instructions for display/debug.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before the debounced button level changes; ≥1.
- OPC_IN, 5'b11100: opcode of the input instruction (switches → register).
- OPC_HLT, 5'b11111: opcode of the halt instruction.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- OpCode  in  5  Instrucao[31:27] of the instruction currently addressed by PC.
- Botao  in  1  raw push-button, active-high, asynchronous to CLK.
- StepMode  in  1  1 = single-step; level sampled every cycle.
- Stall  out  1  drives datapath HLT; 1 = PC holds.
- WriteGate  out  1  ANDed with RegWrite; 0 suppresses register write.
- EsperaEntrada  out  1  1 while in WAIT_IN (LED).
- Parado  out  1  1 while in HALTED (LED).
- InstrCount  out  32  retired-instruction count.

## Operation
- Button path: 2-flop synchronizer → debouncer. Debounced level toggles only after synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any matching cycle clears the counter. Press = one-cycle pulse on debounced rising edge.
- FSM states: RUN, WAIT_IN, STEP_WAIT, HALTED.
- RUN:
  - OpCode==OPC_HLT: Stall=1, WriteGate=0 → HALTED (priority 1).
  - OpCode==OPC_IN: Stall=1, WriteGate=0 → WAIT_IN. A Press in this same cycle is dropped.
  - Else: Stall=0, WriteGate=1. Next state is STEP_WAIT if StepMode=1, otherwise RUN.
- WAIT_IN:
  - No Press: Stall=1, WriteGate=0.
  - Press: Stall=0, WriteGate=1 for exactly that cycle (switch value written, PC advances) → RUN.
- STEP_WAIT:
  - No Press: Stall=1, WriteGate=0.
  - Press: → RUN. No instruction retires in this cycle.
  - StepMode deasserting here does not release; a Press is still required.
- HALTED: Stall=1, WriteGate=0. Press ignored. Exit only via Reset.
- Press pulses in RUN or HALTED are discarded, never queued.
- InstrCount increments by 1 in every cycle with Stall=0 and Reset=0. Wraps 2^32-1 → 0.
- Stall and WriteGate are combinational from state, OpCode and Press. EsperaEntrada, Parado and InstrCount are registered/state-decoded.

## Timing
- Reset asserted (async): state=RUN, synchronizer=0, debounced level=0, debounce counter=0, InstrCount=0.
- Outputs during Reset: Stall=1, WriteGate=0, EsperaEntrada=0, Parado=0, InstrCount=0.
- First instruction may retire on the first rising edge after Reset deasserts.
- Press latency from a clean Botao rising edge: 2 sync cycles + DEBOUNCE_CYCLES, then the pulse.
- Instruction retire in WAIT_IN happens on the same edge that ends the Press cycle.
- Reset mid-wait (WAIT_IN or STEP_WAIT) returns to RUN with no write and the count cleared.

## Structure
- Shared package: OPC_IN and OPC_HLT defaults, FSM state encoding (2 bits).
- Sub-module `debounce_botao`: synchronizer, counter of width clog2(DEBOUNCE_CYCLES+1), and edge pulse. Parameterised by DEBOUNCE_CYCLES.
- Top holds the FSM, output decode and InstrCount.

## Test plan
Bench uses DEBOUNCE_CYCLES=4.
1. Reset, then OpCode=00001 for 10 cycles → Stall=0 and WriteGate=1 throughout; InstrCount=10.
2. OpCode=OPC_IN, then a Botao press held 8 cycles → EsperaEntrada=1; Stall=1 until exactly one cycle with Stall=0 and WriteGate=1, 6 cycles after Botao rises; then RUN.
3. Botao bouncing with 1–3 cycle pulses in WAIT_IN → no Press, Stall stays 1, InstrCount unchanged.
4. StepMode=1 with non-IN opcodes and 3 presses → exactly 3 retirements (InstrCount +3), one per press; Stall=1 between presses.
5. OpCode=OPC_HLT → Parado=1 and Stall=1 permanently; presses ignored; Reset → Parado=0, InstrCount=0.
6. Reset asserted mid-WAIT_IN with Botao held → outputs take reset values immediately; no WriteGate pulse occurs after release.

Source files
------------

// File: rtl/controle_execucao_pkg.sv
// Shared definitions for the execution controller.
//   - Default opcodes for the IN (switches -> register) and HLT instructions.
//   - 2-bit FSM state encoding used by controle_execucao.
package controle_execucao_pkg;

    localparam logic [4:0] OPC_IN_DEFAULT  = 5'b11100;
    localparam logic [4:0] OPC_HLT_DEFAULT = 5'b11111;

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_WAIT_IN   = 2'd1;
    localparam logic [1:0] ST_STEP_WAIT = 2'd2;
    localparam logic [1:0] ST_HALTED    = 2'd3;

endpackage

// File: rtl/controle_execucao_debounce_botao.sv
// Push-button conditioning: 2-flop synchronizer, debouncer and press pulse.
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous active-high reset
//   botao_i  raw push-button level (asynchronous to clk_i)
//   press_o  one-cycle pulse on each debounced rising edge
module debounce_botao #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic botao_i,
    output logic press_o
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The level flips on the cycle that completes a run of DEBOUNCE_CYCLES
    // consecutive disagreeing samples; any agreeing sample restarts the run.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                press_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= botao_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/controle_execucao.sv
// Execution controller for the single-cycle datapath.
// Decodes the current OpCode to gate PC advance and register write-back,
// freezes on IN until a debounced button press, freezes forever on HLT,
// supports single-step mode and counts retired instructions.
// Ports:
//   CLK, Reset     clock, asynchronous active-high reset
//   OpCode         Instrucao[31:27] of the instruction at PC
//   Botao          raw push-button
//   StepMode       1 = single-step
//   Stall          1 = PC holds (datapath HLT)
//   WriteGate      0 = suppress register write
//   EsperaEntrada  1 while waiting for input
//   Parado         1 while halted
//   InstrCount     retired-instruction count
module controle_execucao
    import controle_execucao_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 50000,
    parameter logic [4:0] OPC_IN          = OPC_IN_DEFAULT,
    parameter logic [4:0] OPC_HLT         = OPC_HLT_DEFAULT
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [4:0]  OpCode,
    input  logic        Botao,
    input  logic        StepMode,
    output logic        Stall,
    output logic        WriteGate,
    output logic        EsperaEntrada,
    output logic        Parado,
    output logic [31:0] InstrCount
);

    logic        press;
    logic [1:0]  state_q, state_d;
    logic [31:0] count_q, count_d;
    logic        stall_c, wgate_c;

    debounce_botao #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i   (CLK),
        .rst_i   (Reset),
        .botao_i (Botao),
        .press_o (press)
    );

    // Press pulses outside WAIT_IN / STEP_WAIT fall through unused.
    always_comb begin
        state_d = state_q;
        stall_c = 1'b1;
        wgate_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (OpCode == OPC_HLT) begin
                    state_d = ST_HALTED;
                end else if (OpCode == OPC_IN) begin
                    state_d = ST_WAIT_IN;
                end else begin
                    stall_c = 1'b0;
                    wgate_c = 1'b1;
                    state_d = StepMode ? ST_STEP_WAIT : ST_RUN;
                end
            end
            ST_WAIT_IN: begin
                if (press) begin
                    stall_c = 1'b0;
                    wgate_c = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_STEP_WAIT: begin
                // Release only; the next instruction retires from RUN.
                if (press) state_d = ST_RUN;
            end
            default: state_d = ST_HALTED;
        endcase
    end

    // Reset forces the frozen view on the combinational outputs too.
    assign Stall     = Reset | stall_c;
    assign WriteGate = ~Reset & wgate_c;

    assign count_d = Stall ? count_q : count_q + 32'd1;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_RUN;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign EsperaEntrada = (state_q == ST_WAIT_IN);
    assign Parado        = (state_q == ST_HALTED);
    assign InstrCount    = count_q;

endmodule

// File: tb/tb_controle_execucao.sv
module tb_controle_execucao;

    localparam int         DEB     = 4;
    localparam logic [4:0] OPC_IN  = 5'b11100;
    localparam logic [4:0] OPC_HLT = 5'b11111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  op = 5'd0;
    logic        botao = 1'b0;
    logic        step = 1'b0;
    logic        stall, wgate, espera, parado;
    logic [31:0] icount;

    int checks = 0;
    int errors = 0;
    bit rand_op = 1'b0;

    controle_execucao #(
        .DEBOUNCE_CYCLES(DEB),
        .OPC_IN(OPC_IN),
        .OPC_HLT(OPC_HLT)
    ) dut (
        .CLK           (clk),
        .Reset         (rst),
        .OpCode        (op),
        .Botao         (botao),
        .StepMode      (step),
        .Stall         (stall),
        .WriteGate     (wgate),
        .EsperaEntrada (espera),
        .Parado        (parado),
        .InstrCount    (icount)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Modes: 0 running, 1 waiting for input, 2 waiting for step, 3 halted.
    int          m_mode = 0;
    logic [31:0] m_count = 0;
    bit          m_s1 = 0, m_s2 = 0, m_level = 0, m_press = 0;
    bit          hist[$];

    always @(negedge clk) begin
        bit e_stall, e_wg, toggle;
        int nxt;
        if (rst) begin
            chk("rst_stall", {31'd0, stall}, 32'd1);
            chk("rst_wgate", {31'd0, wgate}, 32'd0);
            chk("rst_espera", {31'd0, espera}, 32'd0);
            chk("rst_parado", {31'd0, parado}, 32'd0);
            chk("rst_count", icount, 32'd0);
            m_mode = 0; m_count = 0;
            m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0;
            hist.delete();
        end else begin
            e_stall = 1'b1; e_wg = 1'b0; nxt = m_mode;
            if (m_mode == 0) begin
                if (op == OPC_HLT) nxt = 3;
                else if (op == OPC_IN) nxt = 1;
                else begin e_stall = 0; e_wg = 1; nxt = step ? 2 : 0; end
            end else if (m_mode == 1) begin
                if (m_press) begin e_stall = 0; e_wg = 1; nxt = 0; end
            end else if (m_mode == 2) begin
                if (m_press) nxt = 0;
            end
            chk("stall", {31'd0, stall}, {31'd0, e_stall});
            chk("wgate", {31'd0, wgate}, {31'd0, e_wg});
            chk("espera", {31'd0, espera}, (m_mode == 1) ? 32'd1 : 32'd0);
            chk("parado", {31'd0, parado}, (m_mode == 3) ? 32'd1 : 32'd0);
            chk("count", icount, m_count);
            m_mode = nxt;
            if (!e_stall) m_count = m_count + 1;
            // debounced level flips once the last DEB synchronized samples all disagree
            hist.push_back(m_s2);
            if (hist.size() > DEB) void'(hist.pop_front());
            toggle = (hist.size() == DEB);
            foreach (hist[i]) if (hist[i] == m_level) toggle = 0;
            m_press = toggle && !m_level;
            if (toggle) begin m_level = !m_level; hist.delete(); end
            m_s2 = m_s1;
            m_s1 = botao;
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [4:0] safe_op();
        logic [4:0] v;
        do v = 5'($urandom_range(0, 31)); while (v == OPC_IN || v == OPC_HLT);
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (rand_op) op = safe_op();
        end
    endtask

    task automatic press_btn(input int hold);
        botao = 1'b1;
        tick(hold);
        botao = 1'b0;
        tick(10);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int first_i, n_ret, wg_seen;
        logic [31:0] c0;

        rst = 1'b1; op = 5'b00001;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stall_lit", {31'd0, stall}, 32'd1);
        chk("reset_count_lit", icount, 32'd0);

        // 1: ten plain instructions
        rst = 1'b0;
        tick(10);
        chk("ten_retired", icount, 32'd10);
        op = OPC_IN;

        // 2: IN waits for one clean press
        tick(1);
        chk("wait_in_led", {31'd0, espera}, 32'd1);
        botao = 1'b1;
        first_i = -1; n_ret = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!stall) begin
                n_ret++;
                if (first_i < 0) first_i = i;
            end
        end
        @(posedge clk); #1;
        botao = 1'b0;
        chk("press_retire_once", n_ret, 32'd1);
        chk("press_latency", first_i, 32'd6);
        chk("count_after_in", icount, 32'd11);
        tick(10);

        // 3: bounces shorter than the debounce window
        c0 = icount;
        repeat (8) begin
            botao = 1'b1; tick($urandom_range(1, 3));
            botao = 1'b0; tick($urandom_range(1, 3));
        end
        tick(8);
        chk("bounce_count", icount, c0);
        chk("bounce_still_wait", {31'd0, espera}, 32'd1);

        // 4: single-step
        rand_op = 1'b1;
        op = safe_op();
        press_btn(8);
        step = 1'b1;
        tick(3);
        c0 = icount;
        chk("step_frozen", {31'd0, stall}, 32'd1);
        repeat (3) press_btn(8);
        chk("step_three", icount, c0 + 32'd3);
        rand_op = 1'b0;

        // random phase
        repeat (200) begin
            botao = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 10)) begin
                @(posedge clk); #1;
                op = ($urandom_range(0, 9) == 0) ? OPC_IN : safe_op();
                step = ($urandom_range(0, 3) == 0);
            end
        end

        // 5: halt
        botao = 1'b0; step = 1'b0; op = safe_op();
        tick(12);
        press_btn(8);
        op = OPC_HLT;
        tick(1);
        chk("halt_led", {31'd0, parado}, 32'd1);
        c0 = icount;
        press_btn(8);
        press_btn(8);
        chk("halt_stays", {31'd0, parado}, 32'd1);
        chk("halt_count", icount, c0);
        rst = 1'b1; #1;
        chk("halt_reset_led", {31'd0, parado}, 32'd0);
        chk("halt_reset_count", icount, 32'd0);
        tick(2);

        // 6: reset in the middle of WAIT_IN
        rst = 1'b0; op = OPC_IN;
        tick(2);
        chk("wait_in_again", {31'd0, espera}, 32'd1);
        botao = 1'b1;
        tick(3);
        rst = 1'b1; #1;
        chk("midwait_stall", {31'd0, stall}, 32'd1);
        chk("midwait_wgate", {31'd0, wgate}, 32'd0);
        chk("midwait_espera", {31'd0, espera}, 32'd0);
        tick(1);
        botao = 1'b0;
        tick(1);
        rst = 1'b0;
        wg_seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (wgate) wg_seen++;
        end
        chk("no_write_after_reset", wg_seen, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
